// File: rtl/jtframe_prog_pkg.sv
// Shared types for the ROM-download staging path: one queued SDRAM write
// entry, output FSM states and the active-low byte-enable encodings.
// Entry address is sized for the widest board and truncated at the ports.
package jtframe_prog_pkg;

  localparam int SDRAMW_MAX = 23;

  typedef struct packed {
    logic [1:0]            ba;
    logic [SDRAMW_MAX-1:0] addr;
    logic [1:0]            mask;
    logic [15:0]           data;
  } prog_entry_t;

  typedef enum logic {IDLE, WAIT} prog_state_t;

  // Active-low byte enables, bit0 = low byte
  localparam logic [1:0] MASK_LO   = 2'b10;
  localparam logic [1:0] MASK_HI   = 2'b01;
  localparam logic [1:0] MASK_W    = 2'b00;
  localparam logic [1:0] MASK_NONE = 2'b11;

endpackage

// File: rtl/jtframe_prog_fifo.sv
// Generic synchronous FIFO, show-ahead head word on dout_o.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: a push when full is accepted only if a pop frees the slot in
// the same cycle; otherwise it is dropped and the caller must notice full_o.
module jtframe_prog_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, rd_q;
  logic             do_push, do_pop;

  // Pointers carry one wrap bit beyond the index
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
  assign count_o = wr_q - rd_q;
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/jtframe_prog_buf.sv
// ioctl byte stream -> SDRAM prog_* port: bank/word translation, FIFO, write FSM.
// Latency: prog_we rises 2 clock edges after the edge sampling ioctl_wr (idle).
// Backpressure: none towards ioctl; bytes arriving to a full FIFO are dropped
// and flagged in sticky overflow. SDRAM side holds prog_we until prog_rdy.
// Ports: ioctl_* byte input, prog_* SDRAM programming port, dwnld_busy keeps
// the game in reset until the last write completes.
// Optional: define JTFRAME_PROG_MERGE_EN to pair even/odd bytes into one word.
module jtframe_prog_buf
  import jtframe_prog_pkg::*;
#(
  parameter int          SDRAMW    = 22,
  parameter int          DEPTH     = 4,
  parameter logic [24:0] BA1_START = 25'h100000,
  parameter logic [24:0] BA2_START = 25'h1FFFFFF,
  parameter logic [24:0] BA3_START = 25'h1FFFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              downloading,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              ioctl_wr,
  output logic [SDRAMW-1:0] prog_addr,
  output logic [15:0]       prog_data,
  output logic [1:0]        prog_mask,
  output logic [1:0]        prog_ba,
  output logic              prog_we,
  input  logic              prog_rdy,
  output logic              dwnld_busy,
  output logic              overflow
);

  localparam int EW = $bits(prog_entry_t);

  function automatic prog_entry_t xlate(input logic [24:0] a, input logic [7:0] d);
    prog_entry_t e;
    logic [24:0] offs;
    e = '0;
    if (a >= BA3_START) begin
      e.ba = 2'd3; offs = a - BA3_START;
    end else if (a >= BA2_START) begin
      e.ba = 2'd2; offs = a - BA2_START;
    end else if (a >= BA1_START) begin
      e.ba = 2'd1; offs = a - BA1_START;
    end else begin
      e.ba = 2'd0; offs = a;
    end
    // word = offs[SDRAMW:1]; anything past the bank size wraps silently
    e.addr = SDRAMW_MAX'((offs >> 1) & ((25'd1 << SDRAMW) - 25'd1));
    e.mask = a[0] ? MASK_HI : MASK_LO;
    e.data = {d, d};
    return e;
  endfunction

  logic        wr_en;
  prog_entry_t cur_ent;
  logic        s1_vld_d, s1_vld_q;
  prog_entry_t s1_ent_d, s1_ent_q;

  assign wr_en   = ioctl_wr & downloading;
  assign cur_ent = xlate(ioctl_addr, ioctl_dout);

`ifdef JTFRAME_PROG_MERGE_EN
  // One-entry hold slot. An even byte waits here for its odd partner; an odd
  // byte lands here only when it displaced a held byte in the same cycle.
  logic        hold_vld_d, hold_vld_q;
  prog_entry_t hold_ent_d, hold_ent_q;
  logic [24:0] hold_baddr_d, hold_baddr_q;
  logic [1:0]  hold_cnt_d, hold_cnt_q;
  logic        partner;

  assign partner = wr_en && hold_ent_q.mask == MASK_LO &&
                   ioctl_addr == 25'(hold_baddr_q + 25'd1) &&
                   cur_ent.ba == hold_ent_q.ba;

  always_comb begin
    s1_vld_d     = 1'b0;
    s1_ent_d     = cur_ent;
    hold_vld_d   = hold_vld_q;
    hold_ent_d   = hold_ent_q;
    hold_baddr_d = hold_baddr_q;
    hold_cnt_d   = hold_cnt_q;
    if (hold_vld_q) begin
      if (partner) begin
        s1_vld_d      = 1'b1;
        s1_ent_d      = hold_ent_q;
        s1_ent_d.mask = MASK_W;
        s1_ent_d.data = {ioctl_dout, hold_ent_q.data[7:0]};
        hold_vld_d    = 1'b0;
      end else if (wr_en || !downloading || hold_cnt_q == 2'd3 ||
                   hold_ent_q.mask != MASK_LO) begin
        // flush the held byte; a new byte (if any) takes over the slot
        s1_vld_d     = 1'b1;
        s1_ent_d     = hold_ent_q;
        hold_vld_d   = wr_en;
        hold_ent_d   = cur_ent;
        hold_baddr_d = ioctl_addr;
        hold_cnt_d   = 2'd0;
      end else begin
        hold_cnt_d = hold_cnt_q + 2'd1;
      end
    end else if (wr_en) begin
      if (ioctl_addr[0]) begin
        s1_vld_d = 1'b1;
      end else begin
        hold_vld_d   = 1'b1;
        hold_ent_d   = cur_ent;
        hold_baddr_d = ioctl_addr;
        hold_cnt_d   = 2'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld_q   <= 1'b0;
      hold_ent_q   <= '0;
      hold_baddr_q <= '0;
      hold_cnt_q   <= '0;
    end else begin
      hold_vld_q   <= hold_vld_d;
      hold_ent_q   <= hold_ent_d;
      hold_baddr_q <= hold_baddr_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end
`else
  always_comb begin
    s1_vld_d = wr_en;
    s1_ent_d = cur_ent;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_ent_q <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_ent_q <= s1_ent_d;
    end
  end

  // FIFO between translation and the SDRAM write FSM
  logic                   fifo_pop, fifo_full, fifo_empty;
  logic [EW-1:0]          fifo_dout;
  logic [$clog2(DEPTH):0] fifo_count;

  jtframe_prog_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (s1_vld_q),
    .din_i   (s1_ent_q),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  prog_state_t st_q;
  prog_entry_t out_q;
  logic        we_q;

  assign fifo_pop = (st_q == IDLE) & ~fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= IDLE;
      we_q  <= 1'b0;
      out_q <= '{ba: 2'd0, addr: '0, mask: MASK_NONE, data: 16'd0};
    end else begin
      case (st_q)
        IDLE: if (!fifo_empty) begin
          out_q <= prog_entry_t'(fifo_dout);
          we_q  <= 1'b1;
          st_q  <= WAIT;
        end
        WAIT: if (prog_rdy) begin
          we_q <= 1'b0;
          st_q <= IDLE;
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign prog_addr = SDRAMW'(out_q.addr);
  assign prog_data = out_q.data;
  assign prog_mask = out_q.mask;
  assign prog_ba   = out_q.ba;
  assign prog_we   = we_q;

  // Sticky overflow, cleared when a new download window opens
  logic dl_q, ovf_q, busy_q, busy_d;

`ifdef JTFRAME_PROG_MERGE_EN
  assign busy_d = downloading | s1_vld_q | hold_vld_q | (fifo_count != '0) | we_q;
`else
  assign busy_d = downloading | s1_vld_q | (fifo_count != '0) | we_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_q   <= 1'b0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      dl_q   <= downloading;
      busy_q <= busy_d;
      if (downloading && !dl_q)                   ovf_q <= 1'b0;
      else if (s1_vld_q && fifo_full && !fifo_pop) ovf_q <= 1'b1;
    end
  end

  assign overflow   = ovf_q;
  assign dwnld_busy = busy_q;

endmodule

// File: tb/tb_jtframe_prog_buf.sv
// Scoreboarded bench for jtframe_prog_buf: directed byte streams push the
// hand-computed SDRAM writes into a queue; a monitor checks each new write.
module tb_jtframe_prog_buf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        downloading = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wr = 1'b0;
  logic [21:0] prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  prog_mask, prog_ba;
  logic        prog_we;
  logic        prog_rdy = 1'b0;
  logic        dwnld_busy, overflow;

  jtframe_prog_buf dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
    .prog_ba(prog_ba), .prog_we(prog_we), .prog_rdy(prog_rdy),
    .dwnld_busy(dwnld_busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  ba;
    logic [21:0] addr;
    logic [1:0]  mask;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_writes = 0;
  int   cyc = 0;
  int   lat_cyc = 0;
  bit   lat_check = 0;
  bit   rdy_en = 1;
  int   rdy_delay = 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic expect_wr(input logic [1:0] ba, input logic [21:0] a,
                           input logic [1:0] m, input logic [15:0] d);
    exp_q.push_back('{ba: ba, addr: a, mask: m, data: d});
  endtask

  // Called at posedge+#1; the byte is sampled by the next edge
  task automatic send(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    @(posedge clk); #1;
    lat_cyc  = cyc;
    ioctl_wr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !prog_we) break;
    end
    if (i == 300) chk({name, "_timeout"}, 64'd1, 64'd0);
    @(posedge clk); #1;
  endtask

  // Waits for a prog_rdy pulse; busy must stay up one more cycle, then fall
  task automatic check_busy_fall(input string name);
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (prog_rdy) break;
    end
    if (i == 300) chk({name, "_rdy_timeout"}, 64'd1, 64'd0);
    @(negedge clk);
    chk({name, "_we_drop"}, prog_we, 1'b0);
    chk({name, "_busy_hold"}, dwnld_busy, 1'b1);
    @(negedge clk);
    chk({name, "_busy_fall"}, dwnld_busy, 1'b0);
    @(posedge clk); #1;
  endtask

  // SDRAM side: one-cycle prog_rdy pulse rdy_delay edges after prog_we
  initial begin : responder
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (prog_rdy) prog_rdy = 1'b0;
      else if (prog_we && rdy_en && rst_n) begin
        cnt++;
        if (cnt >= rdy_delay) begin
          prog_rdy = 1'b1;
          cnt = 0;
        end
      end else cnt = 0;
    end
  end

  initial begin : monitor
    logic  we_prev;
    exp_t  e;
    logic [41:0] held;
    we_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (prog_we && !we_prev) begin
        n_writes++;
        if (lat_check) begin
          chk("latency", 64'(cyc - lat_cyc), 64'd2);
          lat_check = 0;
        end
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {prog_ba, prog_addr, prog_mask, prog_data}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_ba", prog_ba, e.ba);
          chk("wr_addr", prog_addr, e.addr);
          chk("wr_mask", prog_mask, e.mask);
          chk("wr_data", prog_data, e.data);
        end
        held = {prog_ba, prog_addr, prog_mask, prog_data};
      end else if (prog_we && we_prev) begin
        chk("hold_stable", {prog_ba, prog_addr, prog_mask, prog_data}, held);
      end
      we_prev = prog_we;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin : stim
    int wr0;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", prog_we, 1'b0);
    chk("rst_addr", prog_addr, 22'd0);
    chk("rst_data", prog_data, 16'd0);
    chk("rst_mask", prog_mask, 2'b11);
    chk("rst_ba", prog_ba, 2'd0);
    chk("rst_busy", dwnld_busy, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    rst_n = 1'b1;
    idle(2);

    // Write ignored outside a download window
    send(25'h000007, 8'hEE);
    idle(6);
    chk("ignored_wr", 64'(n_writes), 64'd0);

    // Single byte, latency and busy release
    downloading = 1'b1;
    rdy_delay = 3;
    idle(1);
    expect_wr(2'd0, 22'd2, 2'b01, 16'hA5A5);
    lat_check = 1;
    send(25'h000005, 8'hA5);
    downloading = 1'b0;
    check_busy_fall("single");

    // Bank boundary
    downloading = 1'b1;
    rdy_delay = 1;
    idle(1);
    expect_wr(2'd0, 22'h7FFFF, 2'b01, 16'h1111);
    expect_wr(2'd1, 22'h0, 2'b10, 16'h2222);
    send(25'h0FFFFF, 8'h11);
    send(25'h100000, 8'h22);
    wait_drain("bank");

    // Overflow: SDRAM stalled, 7 back-to-back bytes, first 5 survive
    rdy_en = 0;
    for (int i = 0; i < 7; i++) begin
      if (i < 5) expect_wr(2'd0, 22'(8 + i), 2'b01, {2{8'(8'h40 + i)}});
      send(25'(25'h11 + 2 * i), 8'(8'h40 + i));
      if (i == 4) chk("ovf_before", overflow, 1'b0);
    end
    chk("ovf_set", overflow, 1'b1);
    idle(2);
    wr0 = n_writes;
    rdy_en = 1;
    wait_drain("ovf");
    idle(4);
    chk("ovf_writes", 64'(n_writes - wr0), 64'd4);
    chk("ovf_sticky", overflow, 1'b1);
    downloading = 1'b0;
    idle(2);
    downloading = 1'b1;
    idle(1);
    chk("ovf_clear", overflow, 1'b0);

    // Drain after download end
    rdy_en = 0;
    expect_wr(2'd0, 22'h10, 2'b01, 16'hC0C0);
    expect_wr(2'd0, 22'h11, 2'b01, 16'hC1C1);
    expect_wr(2'd0, 22'h12, 2'b01, 16'hC2C2);
    send(25'h21, 8'hC0);
    send(25'h23, 8'hC1);
    send(25'h25, 8'hC2);
    downloading = 1'b0;
    idle(5);
    chk("drain_busy", dwnld_busy, 1'b1);
    rdy_delay = 2;
    rdy_en = 1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) idle(1);
    chk("drain_issued", 64'(exp_q.size()), 64'd0);
    check_busy_fall("drain");

`ifdef JTFRAME_PROG_MERGE_EN
    // Even/odd pair merged into one word, then a lone even byte times out
    downloading = 1'b1;
    rdy_delay = 1;
    idle(1);
    expect_wr(2'd0, 22'd2, 2'b00, 16'h3412);
    send(25'h4, 8'h12);
    idle(1);
    send(25'h5, 8'h34);
    wait_drain("merge");
    expect_wr(2'd0, 22'd4, 2'b10, 16'h5656);
    send(25'h8, 8'h56);
    wait_drain("merge_lone");
    downloading = 1'b0;
    idle(2);
`endif

    // Reset in the middle of a stalled write with a full FIFO
    downloading = 1'b1;
    rdy_en = 0;
    idle(1);
    expect_wr(2'd0, 22'h18, 2'b01, 16'h6060);
    for (int i = 0; i < 7; i++) send(25'(25'h31 + 2 * i), 8'(8'h60 + i));
    idle(2);
    chk("pre_rst_we", prog_we, 1'b1);
    chk("pre_rst_ovf", overflow, 1'b1);
    rst_n = 1'b0;
    downloading = 1'b0;
    #1;
    chk("mid_rst_we", prog_we, 1'b0);
    chk("mid_rst_ovf", overflow, 1'b0);
    chk("mid_rst_busy", dwnld_busy, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rdy_en = 1;
    wr0 = n_writes;
    idle(20);
    chk("post_rst_writes", 64'(n_writes - wr0), 64'd0);
    chk("post_rst_busy", dwnld_busy, 1'b0);

    chk("leftover_expected", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
